// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (RUN / WAIT / DROP / HALT)
//   fetch_entry_t : one instruction buffer entry {pc, instr, misaligned}
//   NOP_INSTR     : instruction presented when nothing valid is buffered
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,   // no request outstanding
      ST_WAIT = 2'd1,   // one request outstanding, response wanted
      ST_DROP = 2'd2,   // one request outstanding, response to be discarded
      ST_HALT = 2'd3    // stopped on a misaligned target
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        misaligned;
   } fetch_entry_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Synchronous FIFO of fetch_entry_t with a flush input.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (pointers/count)
//   flush             : empties the FIFO; a push in the same cycle becomes
//                       the sole entry
//   push, push_data   : write one entry
//   pop               : remove the head entry (ignored when empty)
//   head              : current head entry (undefined when empty)
//   empty, count      : occupancy
// -----------------------------------------------------------------------------
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   output fetch_entry_t     head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W-1:0] r_wr;
   logic [CNT_W-1:0] r_cnt;
   logic [PTR_W-1:0] w_wr_idx;
   logic             w_push;
   logic             w_pop;

   // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_push   = push && (flush || (r_cnt != CNT_W'(DEPTH)));
   assign w_pop    = pop && !flush && (r_cnt != '0);
   // A push that coincides with a flush lands in slot 0 of the emptied FIFO.
   assign w_wr_idx = flush ? '0 : r_wr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else if (flush) begin
         r_rd  <= '0;
         r_wr  <= push ? ptr_inc('0) : '0;
         r_cnt <= push ? CNT_W'(1) : '0;
      end else begin
         if (w_push) r_wr <= ptr_inc(r_wr);
         if (w_pop)  r_rd <= ptr_inc(r_rd);
         if (w_push && !w_pop)
            r_cnt <= r_cnt + CNT_W'(1);
         else if (!w_push && w_pop)
            r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Storage is data only; occupancy is tracked by the control registers.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[w_wr_idx] <= push_data;
   end

   assign head  = r_mem[r_rd];
   assign empty = (r_cnt == '0);
   assign count = r_cnt;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: issues one word request at a time to instruction memory,
// buffers responses in fetch_buffer and presents the head entry to IF/ID.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a misaligned redirect target flushes, presents one flagged
//               NOP entry at that PC and halts fetch until the next redirect
//   undefined : redirect target bits [1:0] are forced to 00,
//               f_misaligned is tied 0
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   enable                  : IF/ID accepts the presented instruction
//   redirect, redirect_pc   : restart fetch at redirect_pc
//   imem_req, imem_addr     : memory request / word address
//   imem_ready              : memory accepts the request this cycle
//   imem_rvalid, imem_rdata : memory response
//   f_instr, f_pc, f_valid  : instruction to IF/ID, its PC, valid
//   f_misaligned            : head entry came from a misaligned target
// -----------------------------------------------------------------------------
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] f_instr,
   output logic [31:0] f_pc,
   output logic        f_valid,
   output logic        f_misaligned
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   fetch_state_t     r_state;
   fetch_state_t     w_state_nxt;
   logic [31:0]      r_pc;
   logic [31:0]      r_req_pc;
   logic [31:0]      r_last_pc;
   logic [31:0]      w_redir_pc;
   logic             w_mis_redir;
   logic             w_hs;
   logic             w_push;
   logic             w_pop;
   logic             w_empty;
   logic             w_room;
   logic [CNT_W-1:0] w_count;
   fetch_entry_t     w_push_data;
   fetch_entry_t     w_head;
   logic             w_unused_bits;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign w_mis_redir   = redirect && (redirect_pc[1:0] != 2'b00);
   assign w_redir_pc    = redirect_pc;
   assign w_unused_bits = 1'b0;
`else
   assign w_mis_redir   = 1'b0;
   assign w_redir_pc    = {redirect_pc[31:2], 2'b00};
   assign w_unused_bits = ^{redirect_pc[1:0], w_head.misaligned};
`endif

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_RUN;
      else       r_state <= w_state_nxt;
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      if (redirect) begin
         if (w_mis_redir)
            w_state_nxt = ST_HALT;
         else if ((r_state == ST_WAIT) || (r_state == ST_DROP))
            // A response arriving with the redirect retires the outstanding
            // request; otherwise it is still in flight and must be dropped.
            w_state_nxt = imem_rvalid ? ST_RUN : ST_DROP;
         else
            w_state_nxt = ST_RUN;
      end else begin
         case (r_state)
            ST_RUN:  if (w_hs)        w_state_nxt = ST_WAIT;
            ST_WAIT: if (imem_rvalid) w_state_nxt = ST_RUN;
            ST_DROP: if (imem_rvalid) w_state_nxt = ST_RUN;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // FSM: outputs and buffer controls
   always_comb begin
      w_room   = (w_count < CNT_W'(BUF_DEPTH));
      imem_req = !reset && (r_state == ST_RUN) && w_room && !redirect;
      w_hs     = imem_req && imem_ready;
      w_push   = !reset && (w_mis_redir ||
                 ((r_state == ST_WAIT) && imem_rvalid && !redirect));
      w_pop    = !w_empty && enable;
      if (w_mis_redir) begin
         w_push_data.pc         = redirect_pc;
         w_push_data.instr      = NOP_INSTR;
         w_push_data.misaligned = 1'b1;
      end else begin
         w_push_data.pc         = r_req_pc;
         w_push_data.instr      = imem_rdata;
         w_push_data.misaligned = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)         r_pc <= RESET_PC;
      else if (redirect) r_pc <= w_redir_pc;
      else if (w_hs)     r_pc <= r_pc + 32'd4;   // wraps silently at 2^32
   end

   // PC of the outstanding request, paired with its response on push.
   always_ff @(posedge clk) begin
      if (w_hs) r_req_pc <= r_pc;
   end

   // Remembers the last presented PC so f_pc holds while the buffer is empty.
   always_ff @(posedge clk) begin
      if (reset)         r_last_pc <= RESET_PC;
      else if (!w_empty) r_last_pc <= w_head.pc;
   end

   fetch_buffer #(
      .DEPTH (BUF_DEPTH),
      .CNT_W (CNT_W)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .head      (w_head),
      .empty     (w_empty),
      .count     (w_count)
   );

   assign imem_addr = r_pc;
   assign f_valid   = !reset && !w_empty;
   assign f_instr   = f_valid ? w_head.instr : NOP_INSTR;
   assign f_pc      = reset ? RESET_PC : (w_empty ? r_last_pc : w_head.pc);
`ifdef FETCH_MISALIGN_CHECK_EN
   assign f_misaligned = f_valid && w_head.misaligned;
`else
   assign f_misaligned = 1'b0;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, SHALL be the instruction buffer depth in entries (legal: 2..4).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  downstream (IF/ID) accepts the presented instruction this cycle.
REQ-006 redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 imem_req  output  1  instruction memory request valid.
REQ-009 imem_addr  output  32  request word address (byte address, [1:0]=00).
REQ-010 imem_ready  input  1  memory accepts request this cycle (handshake = imem_req & imem_ready).
REQ-011 imem_rvalid  input  1  response data valid; arrives at least 1 cycle after handshake.
REQ-012 imem_rdata  input  32  response instruction word.
REQ-013 f_instr  output  32  instruction to IF/ID register.
REQ-014 f_pc  output  32  PC of f_instr.
REQ-015 f_valid  output  1  f_instr/f_pc hold a valid fetched instruction.
REQ-016 f_misaligned  output  1  fetch-address-misaligned flag for the current entry.

Function
REQ-017 Internal fetch PC SHALL advance by 4 on each request handshake; 32-bit wrap 32'hFFFF_FFFC -> 32'h0000_0000 SHALL be silent.
REQ-018 At most one request SHALL be outstanding; states RUN (none outstanding), WAIT (one outstanding), DROP (outstanding response to discard), HALT (macro only).
REQ-019 imem_req SHALL be 1 only in RUN when (buffer count) < BUF_DEPTH and redirect=0; handshake moves RUN->WAIT.
REQ-020 In WAIT, imem_rvalid SHALL push {fetch PC of request, imem_rdata} into the buffer and return to RUN; a new request is issuable the following cycle.
REQ-021 f_valid SHALL equal buffer non-empty; f_instr/f_pc SHALL show the head entry, and 32'h0000_0013 (NOP) / last f_pc when empty.
REQ-022 Pop SHALL occur when f_valid & enable; with enable=0 outputs SHALL hold unchanged.
REQ-023 Push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-024 Latency: rvalid at edge N -> f_valid=1 from cycle N+1.
REQ-025 redirect=1 SHALL flush the buffer, load fetch PC with redirect_pc, and move WAIT->DROP, RUN->RUN, DROP->DROP; flush SHALL win over a simultaneous pop or push.
REQ-026 In DROP, imem_rvalid SHALL be discarded and state SHALL return to RUN.
REQ-027 redirect coincident with imem_rvalid in WAIT SHALL discard that response and go to RUN.

Reset
REQ-028 reset SHALL set fetch PC=RESET_PC, state=RUN, buffer empty, f_valid=0, f_instr=32'h0000_0013, f_pc=RESET_PC, f_misaligned=0, imem_req=0 during the reset cycle.
REQ-029 reset SHALL override redirect and any in-flight response; a response arriving after reset for a pre-reset request is the system's responsibility (memory is reset together).

Configuration
REQ-030 With FETCH_MISALIGN_CHECK_EN defined, redirect_pc[1:0]!=0 SHALL flush, push one entry {pc=redirect_pc, instr=NOP, misaligned=1}, enter HALT (no requests) until the next redirect or reset.
REQ-031 Without FETCH_MISALIGN_CHECK_EN, redirect_pc[1:0] SHALL be forced to 00 and f_misaligned SHALL be tied 0.

Structure
REQ-032 Package fetch_pkg SHALL hold fetch_state_t enum, fetch_entry_t struct {pc, instr, misaligned}, and NOP_INSTR constant 32'h0000_0013.
REQ-033 Buffer SHALL be a sub-module fetch_buffer (parameterised synchronous FIFO of fetch_entry_t, flush input).

Verification
REQ-034 Reset release, memory ready=1, rvalid 1 cycle later with rdata=32'h00A1: f_valid=1, f_instr=32'h00A1, f_pc=0; next request addr 32'h4.
REQ-035 enable=0 for 10 cycles: buffer fills to 2, imem_req drops to 0, f_* stable; enable=1 -> entries pop in order pc 0, 4.
REQ-036 redirect to 32'h49C while WAIT: outstanding response dropped, next imem_addr=32'h49C, first f_pc=32'h49C.
REQ-037 redirect and imem_rvalid same cycle: response not seen at f_*, buffer empty, f_valid=0 next cycle.
REQ-038 FETCH_MISALIGN_CHECK_EN, redirect_pc=32'h49: f_valid=1, f_misaligned=1, f_pc=32'h49, f_instr=NOP, imem_req stays 0 until redirect to 32'h100.
REQ-039 Mid-operation reset with 2 buffered entries: next cycle f_valid=0, imem_addr=RESET_PC on first request.
